// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder: FSM encoding, symbol limits and
// the (length, pattern) -> letter index lookup.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam logic [4:0] LETTER_INVALID   = 5'd31;
  localparam int         DOT_MAX_UNITS    = 1;
  localparam int         LETTER_GAP_UNITS = 3;
  localparam int         MAX_ELEMENTS     = 4;
  localparam int         LEN_W            = 3;
  localparam int         PAT_W            = 4;

  // Pattern holds elements with the first one at the MSB of the used bits;
  // 1 = dash. An overflowed symbol is never a letter.
  function automatic logic [4:0] letter_lookup(input logic [LEN_W-1:0] len,
                                               input logic [PAT_W-1:0] pat,
                                               input logic             ovf);
    logic [4:0] idx;
    idx = LETTER_INVALID;
    if (!ovf) begin
      case (len)
        3'd1: idx = pat[0] ? 5'd19 : 5'd4;                 // T / E
        3'd2: begin
          case (pat[1:0])
            2'b00:   idx = 5'd8;                           // I
            2'b01:   idx = 5'd0;                           // A
            2'b10:   idx = 5'd13;                          // N
            default: idx = 5'd12;                          // M
          endcase
        end
        3'd3: begin
          case (pat[2:0])
            3'b000:  idx = 5'd18;                          // S
            3'b001:  idx = 5'd20;                          // U
            3'b010:  idx = 5'd17;                          // R
            3'b011:  idx = 5'd22;                          // W
            3'b100:  idx = 5'd3;                           // D
            3'b101:  idx = 5'd10;                          // K
            3'b110:  idx = 5'd6;                           // G
            default: idx = 5'd14;                          // O
          endcase
        end
        3'd4: begin
          case (pat)
            4'b0000: idx = 5'd7;                           // H
            4'b0001: idx = 5'd21;                          // V
            4'b0010: idx = 5'd5;                           // F
            4'b0100: idx = 5'd11;                          // L
            4'b0110: idx = 5'd15;                          // P
            4'b0111: idx = 5'd9;                           // J
            4'b1000: idx = 5'd1;                           // B
            4'b1001: idx = 5'd23;                          // X
            4'b1010: idx = 5'd2;                           // C
            4'b1011: idx = 5'd24;                          // Y
            4'b1100: idx = 5'd25;                          // Z
            4'b1101: idx = 5'd16;                          // Q
            default: idx = LETTER_INVALID;                 // 0011 0101 1110 1111
          endcase
        end
        default: idx = LETTER_INVALID;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Morse unit timebase: phase counter 0..UNIT_CYCLES-1 with a tick on the last
// count. A restart pulls the phase back to 0 so units are measured from the
// most recent key edge.
module morse_unit_tick
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int              PH_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UNIT_CYCLES - 1);

  logic [PH_W-1:0] phase_q, phase_d;

  // Next phase and tick decode; tick is not masked by restart so an edge on
  // the last count still delivers its unit.
  always_comb begin
    tick_o  = (phase_q == PH_LAST);
    phase_d = phase_q + PH_W'(1);
    if (restart_i || tick_o) begin
      phase_d = '0;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: synchronises the key, times marks and spaces in units,
// assembles dot/dash elements and emits one letter index per symbol.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no symbol in progress, waiting for a key press
//   ST_MARK  | key held, counting mark units
//   ST_SPACE | key released, counting gap units toward the letter gap
module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000,
  parameter int UNIT_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_i,
  output logic [4:0] letter_o,
  output logic       valid_o,
  output logic       error_o,
  output logic       busy_o
);

  localparam logic [UNIT_W-1:0] UNIT_SAT = {UNIT_W{1'b1}};
  localparam logic [UNIT_W-1:0] DOT_MAX  = UNIT_W'(DOT_MAX_UNITS);
  localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'(LETTER_GAP_UNITS - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_ELEMENTS);

  logic key_meta_q, key_meta_d;
  logic key_s_q, key_s_d;
  logic key_dly_q, key_dly_d;
  logic rise, fall, tick, emit, dash;

  state_t             state_q, state_d;
  logic [UNIT_W-1:0]  mark_units_q, mark_units_d;
  logic [UNIT_W-1:0]  space_units_q, space_units_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               ovf_q, ovf_d;
  logic [4:0]         letter_q, letter_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [4:0]         letter_lut;

  // Two-flop synchroniser followed by the edge-detect register.
  always_comb begin
    key_meta_d = key_i;
    key_s_d    = key_meta_q;
    key_dly_d  = key_s_q;
    rise       = key_s_q & ~key_dly_q;
    fall       = ~key_s_q & key_dly_q;
  end

  // Key pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_dly_q  <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_s_q    <= key_s_d;
      key_dly_q  <= key_dly_d;
    end
  end

  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(rise | fall),
    .tick_o   (tick)
  );

  assign emit       = (state_q == ST_SPACE) && tick && (space_units_q == GAP_LAST);
  assign dash       = (mark_units_q > DOT_MAX);
  assign letter_lut = letter_lookup(len_q, pat_q, ovf_q);

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state; a rise on the emitting tick goes straight to a new mark.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise) state_d = ST_MARK;
      ST_MARK:  if (fall) state_d = ST_SPACE;
      ST_SPACE: begin
        if (emit)      state_d = rise ? ST_MARK : ST_IDLE;
        else if (rise) state_d = ST_MARK;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Symbol datapath: unit counters and element accumulation.
  always_comb begin
    mark_units_d  = mark_units_q;
    space_units_d = space_units_q;
    len_d         = len_q;
    pat_d         = pat_q;
    ovf_d         = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          len_d        = '0;
          pat_d        = '0;
          ovf_d        = 1'b0;
          mark_units_d = '0;
        end
      end
      ST_MARK: begin
        if (fall) begin
          pat_d         = {pat_q[PAT_W-2:0], dash};
          space_units_d = '0;
          if (len_q == LEN_MAX) ovf_d = 1'b1;
          else                  len_d = len_q + LEN_W'(1);
        end else if (tick && mark_units_q != UNIT_SAT) begin
          mark_units_d = mark_units_q + UNIT_W'(1);
        end
      end
      ST_SPACE: begin
        if (rise) begin
          mark_units_d = '0;
          if (emit) begin
            len_d = '0;
            pat_d = '0;
            ovf_d = 1'b0;
          end
        end else if (tick && space_units_q != UNIT_SAT) begin
          space_units_d = space_units_q + UNIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mark_units_q  <= '0;
      space_units_q <= '0;
      len_q         <= '0;
      pat_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      mark_units_q  <= mark_units_d;
      space_units_q <= space_units_d;
      len_q         <= len_d;
      pat_q         <= pat_d;
      ovf_q         <= ovf_d;
    end
  end

  // FSM outputs: letter and error load on emission and hold otherwise.
  always_comb begin
    valid_d  = emit;
    letter_d = letter_q;
    error_d  = error_q;
    if (emit) begin
      letter_d = letter_lut;
      error_d  = (letter_lut == LETTER_INVALID);
    end
    busy_o = (state_q != ST_IDLE) | valid_q;
  end

  // Registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      letter_q <= LETTER_INVALID;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter_o = letter_q;
  assign valid_o  = valid_q;
  assign error_o  = error_q;

endmodule
